// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM states and instruction constants.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register plus a four-state fetch FSM driving a
// synchronous instruction ROM and holding the fetched word in the IR.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_req,
    input  logic             ir_ack,
    input  logic             redirect,
    input  logic [DEPTH-1:0] redirect_pc,
    output logic [DEPTH-1:0] imem_addr,
    output logic             imem_rd,
    input  logic [WIDTH-1:0] imem_data,
    output logic [WIDTH-1:0] instr,
    output logic [DEPTH-1:0] instr_pc,
    output logic             instr_valid,
    output logic             misaligned
);

    localparam logic [DEPTH-1:0] ALIGN_MASK = ~DEPTH'(INSTR_BYTES - 1);
    localparam logic [DEPTH-1:0] RESET_ADDR = DEPTH'(RESET_PC) & ALIGN_MASK;
    localparam logic [DEPTH-1:0] PC_STEP    = DEPTH'(INSTR_BYTES);

    fetch_state_t     state, state_nxt;
    logic [DEPTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] instr_nxt;
    logic [DEPTH-1:0] instr_pc_nxt;
    logic             instr_valid_nxt;
    logic             misaligned_nxt;
    logic             imem_rd_nxt;
    logic [DEPTH-1:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ALIGN_MASK;
    assign imem_addr    = pc;

    // Next-state and next-register values; redirect overrides the PC in every state.
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        misaligned_nxt  = redirect && (redirect_pc[1:0] != 2'b00);

        case (state)
            IDLE: begin
                if (fetch_req && !redirect) state_nxt = ISSUE;
            end
            ISSUE: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (!redirect) begin
                    instr_nxt       = imem_data;
                    instr_pc_nxt    = pc;
                    instr_valid_nxt = 1'b1;
                    pc_nxt          = pc + PC_STEP;
                    state_nxt       = HOLD;
                end
            end
            HOLD: begin
                if (ir_ack && instr_valid) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = fetch_req ? ISSUE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A redirect during an in-flight read discards it and refetches from the target.
        if (redirect) begin
            pc_nxt = redirect_tgt;
            if (state == ISSUE || state == CAPTURE) state_nxt = ISSUE;
        end

        imem_rd_nxt = (state_nxt == ISSUE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= RESET_ADDR;
            instr       <= WIDTH'(NOP_INSTR);
            instr_pc    <= RESET_ADDR;
            instr_valid <= 1'b0;
            misaligned  <= 1'b0;
            imem_rd     <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            misaligned  <= misaligned_nxt;
            imem_rd     <= imem_rd_nxt;
        end
    end

endmodule
